keypad_scanner: RTL and testbench

//   Input-side counterpart of the time-multiplexed display driver: drives a 4x4 matrix keypad one

---
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scanner.sv | 178 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: the matrix-side signals (rows in, column drive out)
// plus the decoded key stream that feeds the dual-digit display path.
//   rows       keypad rows, active-low, asynchronous to clk
//   cols       column drive, active-low, one bit low at a time
//   key        hex code of the last accepted key
//   key_valid  one-clk pulse per accepted key
//   digit_new  most recent key
//   digit_old  previous key
// master = scanner, slave = keypad / display consumer.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  modport master (
    input  rows,
    output cols, key, key_valid, digit_new, digit_old
  );

  modport slave (
    output rows,
    input  cols, key, key_valid, digit_new, digit_old
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one column low at a time, samples the
// synchronised rows once per scan tick, debounces presses and releases, and
// decodes the accepted key to hex while keeping the last two keys entered.
//   clk    system clock
//   reset  asynchronous active-low reset
//   kp     keypad_scanner_if.master: rows in; cols, key, key_valid,
//          digit_new, digit_old out
module keypad_scanner #(
  parameter int SCAN_DIV       = 24000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] r);
    logic [3:0] lo;
    lo = ~r;
    return (lo != 4'd0) && ((lo & (lo - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    case (r)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;
      4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;
      default:  return 4'hD;
    endcase
  endfunction

  logic [3:0]    rows_p0, rows_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  state_t        state, state_n;
  logic [1:0]    col, col_n, row, row_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n, cnt_inc, rcnt_inc;
  logic          hit, accept;
  logic [1:0]    hit_row;
  logic [3:0]    key_dec;
  logic [3:0]    key_r, dnew_r, dold_r;
  logic          kv_r;

  assign tick     = (tick_cnt == TW'(SCAN_DIV - 1));
  assign hit      = single_low(rows_s);
  assign hit_row  = low_index(rows_s);
  // Counters saturate at the threshold rather than wrapping.
  assign cnt_inc  = (cnt  < CW'(DEBOUNCE_SCANS)) ? cnt  + CW'(1) : cnt;
  assign rcnt_inc = (rcnt < CW'(DEBOUNCE_SCANS)) ? rcnt + CW'(1) : rcnt;
  assign key_dec  = decode(row_n, col);

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            row_n = hit_row;
            cnt_n = CW'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              state_n = HELD;
              rcnt_n  = '0;
              accept  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && (hit_row == row)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_n = HELD;
              rcnt_n  = '0;
              accept  = 1'b1;
            end
          end else begin
            // Bounce or a different key: abandon and keep scanning.
            state_n = SCAN;
            col_n   = col + 2'd1;
            cnt_n   = '0;
          end
        end
        HELD: begin
          // Column stays frozen, so keys on other columns are invisible here.
          if (rows_s == 4'b1111) begin
            if (rcnt_inc == CW'(DEBOUNCE_SCANS)) begin
              state_n = SCAN;
              col_n   = col + 2'd1;
              rcnt_n  = '0;
            end else begin
              rcnt_n = rcnt_inc;
            end
          end else begin
            rcnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_p0  <= 4'b1111;
      rows_s   <= 4'b1111;
      tick_cnt <= '0;
      state    <= SCAN;
      col      <= 2'd0;
      row      <= 2'd0;
      cnt      <= '0;
      rcnt     <= '0;
      kv_r     <= 1'b0;
      key_r    <= 4'd0;
      dnew_r   <= 4'd0;
      dold_r   <= 4'd0;
    end else begin
      // Stage p0 -> s: two-flop row synchroniser
      rows_p0  <= kp.rows;
      rows_s   <= rows_p0;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      // FSM registers, updated on tick only
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      cnt      <= cnt_n;
      rcnt     <= rcnt_n;
      // Key output and digit history, updated together with key_valid
      kv_r     <= accept;
      if (accept) begin
        key_r  <= key_dec;
        dold_r <= dnew_r;
        dnew_r <= key_dec;
      end
    end
  end

  assign kp.cols      = ~(4'b0001 << col);
  assign kp.key       = key_r;
  assign kp.key_valid = kv_r;
  assign kp.digit_new = dnew_r;
  assign kp.digit_old = dold_r;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if ifc();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (ifc)
  );

  // Keypad model: pressed[r*4+c]; a row reads low only while its key's column is driven low.
  logic [15:0] pressed = '0;
  logic [3:0]  rows_drv;
  always_comb begin
    rows_drv = 4'b1111;
    for (int r = 0; r < 4; r++)
      rows_drv[r] = ~|(pressed[r*4 +: 4] & ~ifc.cols);
  end
  assign ifc.rows = rows_drv;

  // Reference keymap (row-major) and digit history.
  logic [3:0] km [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                          4'h4, 4'h5, 4'h6, 4'hB,
                          4'h7, 4'h8, 4'h9, 4'hC,
                          4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct packed {
    logic [3:0] key;
    logic [3:0] dnew;
    logic [3:0] dold;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_new = 4'd0;
  logic [3:0] m_old = 4'd0;
  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_press(input int idx);
    m_old = m_new;
    m_new = km[idx];
    q.push_back('{km[idx], m_new, m_old});
  endtask

  task automatic ticks(input int n);
    repeat (n * SCAN_DIV) @(posedge clk);
  endtask

  task automatic wait_pulse(input int base, input int max_ticks);
    int k;
    k = 0;
    while (pulses == base && k < max_ticks * SCAN_DIV) begin
      @(posedge clk);
      k++;
    end
    check("key_valid_arrived", 32'(pulses > base), 1);
  endtask

  task automatic wait_col(input logic [3:0] c);
    int k;
    k = 0;
    @(posedge clk); #1;
    while (ifc.cols !== c && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_column", ifc.cols, c);
  endtask

  task automatic check_rotation(input int n);
    logic [3:0] prev;
    @(posedge clk); #1;
    prev = ifc.cols;
    repeat (n) begin
      repeat (SCAN_DIV) @(posedge clk);
      #1;
      check("col_onehot", $countones(~ifc.cols), 1);
      check("col_rotate", ifc.cols, {prev[2:0], prev[3]});
      prev = ifc.cols;
    end
  endtask

  // Monitor: pops the scoreboard on every key_valid; outputs must not move otherwise.
  initial begin
    logic       prev_kv;
    logic [3:0] lk, ln, lo;
    exp_t       e;
    prev_kv = 1'b0; lk = 4'd0; ln = 4'd0; lo = 4'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_kv = 1'b0; lk = 4'd0; ln = 4'd0; lo = 4'd0;
      end else begin
        if (ifc.key_valid) begin
          pulses++;
          check("kv_width", 32'(prev_kv), 0);
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_key_valid: got key %0h, required no pulse (t=%0t)", ifc.key, $time);
          end else begin
            e = q.pop_front();
            check("key", ifc.key, e.key);
            check("digit_new", ifc.digit_new, e.dnew);
            check("digit_old", ifc.digit_old, e.dold);
          end
        end else begin
          check("outputs_hold", {ifc.key, ifc.digit_new, ifc.digit_old}, {lk, ln, lo});
        end
        prev_kv = ifc.key_valid;
        lk = ifc.key; ln = ifc.digit_new; lo = ifc.digit_old;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int idx;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cols", ifc.cols, 4'b1110);
    check("rst_key", ifc.key, 0);
    check("rst_kv", ifc.key_valid, 0);
    check("rst_dnew", ifc.digit_new, 0);
    check("rst_dold", ifc.digit_old, 0);
    @(negedge clk);
    reset = 1'b1;

    // '5' held 40 ticks, release 3 ticks, then 'A'.
    p = pulses;
    pressed[5] = 1'b1;
    expect_press(5);
    ticks(40);
    check("hold5_one_pulse", pulses - p, 1);
    pressed = '0;
    ticks(3);
    repeat (2) @(posedge clk);
    pressed[3] = 1'b1;
    expect_press(3);
    ticks(15);
    pressed = '0;
    ticks(6);
    check("five_then_a_pulses", pulses - p, 2);

    // Reset asserted while 'B' is held.
    p = pulses;
    pressed[7] = 1'b1;
    expect_press(7);
    wait_pulse(p, 20);
    ticks(2);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("midheld_cols", ifc.cols, 4'b1110);
    check("midheld_kv", ifc.key_valid, 0);
    check("midheld_key", ifc.key, 0);
    check("midheld_dnew", ifc.digit_new, 0);
    check("midheld_dold", ifc.digit_old, 0);
    check("midheld_pending", q.size(), 0);
    q.delete();
    m_new = 4'd0;
    m_old = 4'd0;
    pressed = '0;
    ticks(2);
    @(negedge clk);
    reset = 1'b1;
    check_rotation(5);

    // One-tick bounce on r1 while c1 is driven.
    p = pulses;
    wait_col(4'b1101);
    pressed[5] = 1'b1;
    ticks(1);
    pressed = '0;
    ticks(3);
    check("bounce_no_pulse", pulses - p, 0);
    check_rotation(6);

    // '5' held, '9' added, '5' released: '9' never accepted.
    p = pulses;
    pressed[5] = 1'b1;
    expect_press(5);
    wait_pulse(p, 20);
    pressed[10] = 1'b1;
    ticks(3);
    pressed[5] = 1'b0;
    ticks(2);
    pressed[10] = 1'b0;
    ticks(8);
    check("five_nine_pulses", pulses - p, 1);

    // '5' held, '8' on the same column added, '5' released: stays held.
    p = pulses;
    pressed[5] = 1'b1;
    expect_press(5);
    wait_pulse(p, 20);
    pressed[9] = 1'b1;
    ticks(2);
    pressed[5] = 1'b0;
    ticks(10);
    #1;
    check("held_col_frozen", ifc.cols, 4'b1101);
    check("five_eight_pulses", pulses - p, 1);
    pressed = '0;
    ticks(6);

    // r0 and r2 low together on c0: no hit, columns keep cycling.
    p = pulses;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    check_rotation(12);
    pressed = '0;
    ticks(3);
    check("multirow_no_pulse", pulses - p, 0);

    // Randomised presses and bounces.
    for (int i = 0; i < 16; i++) begin
      idx = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        pressed[idx] = 1'b1;
        ticks(1);
        pressed = '0;
      end else begin
        expect_press(idx);
        pressed[idx] = 1'b1;
        ticks(int'($urandom_range(12, 30)));
        pressed = '0;
      end
      ticks(int'($urandom_range(5, 9)));
    end
    ticks(4);
    check("scoreboard_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
